// File: rtl/writeback_register_file.sv
// Writeback stage plus 32x32 register file.
// Selects the writeback value (ALU result or a big-endian extracted load),
// writes it into the register file on the rising clock edge, and serves two
// combinational read ports that see a same-cycle write (write-before-read).
module writeback_register_file #(
  parameter logic [31:0] SP_RESET_VALUE = 32'h0000_0000,
  parameter logic [31:0] GP_RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        register_write_writeback,
  input  logic        memory_to_register_writeback,
  input  logic [31:0] ALU_out_writeback,
  input  logic [31:0] read_data_writeback,
  input  logic [2:0]  load_type_writeback,
  input  logic [4:0]  write_register_writeback,
  input  logic [4:0]  read_address_1,
  input  logic [4:0]  read_address_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] result_writeback,
  output logic [31:0] register_v0
);

  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LB  = 3'b001,
    LOAD_LBU = 3'b010,
    LOAD_LH  = 3'b011,
    LOAD_LHU = 3'b100
  } load_type_e;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned GP_INDEX = 28;
  localparam int unsigned SP_INDEX = 29;
  localparam int unsigned V0_INDEX = 2;

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [1:0]  offset;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic        write_hit;

  assign offset = ALU_out_writeback[1:0];

  // Write is effective only when enabled and not aimed at the hardwired zero register.
  assign write_hit = register_write_writeback && (write_register_writeback != 5'd0);

  // Big-endian byte/halfword selection and sign/zero extension of the load word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    load_byte  = read_data_writeback[31:24];
    load_half  = offset[1] ? read_data_writeback[15:0] : read_data_writeback[31:16];
    load_value = read_data_writeback;

    unique case (offset)
      2'd0: load_byte = read_data_writeback[31:24];
      2'd1: load_byte = read_data_writeback[23:16];
      2'd2: load_byte = read_data_writeback[15:8];
      2'd3: load_byte = read_data_writeback[7:0];
    endcase

    case (load_type_writeback)
      LOAD_LB:  load_value = {{24{load_byte[7]}}, load_byte};
      LOAD_LBU: load_value = {24'd0, load_byte};
      LOAD_LH:  load_value = {{16{load_half[15]}}, load_half};
      LOAD_LHU: load_value = {16'd0, load_half};
      default:  load_value = read_data_writeback;  // LW and unused encodings
    endcase
  end

  // Final writeback value, also consumed by the forwarding unit.
  always_comb begin
    result_writeback = ALU_out_writeback;
    if (memory_to_register_writeback) begin
      result_writeback = load_value;
    end
  end

  // Next register-file contents: hold everything, update the addressed entry.
  always_comb begin
    regs_d = regs_q;
    if (write_hit) begin
      regs_d[write_register_writeback] = result_writeback;
    end
  end

  // Register-file state; reset loads the $gp/$sp reset values, zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this array is reset because $sp/$gp must hold defined values and software may read other registers before writing them; a plain RAM macro would not be used here.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[GP_INDEX] <= GP_RESET_VALUE;
      regs_q[SP_INDEX] <= SP_RESET_VALUE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero register reads 0, same-cycle write bypasses storage.
  always_comb begin
    read_data_1 = (read_address_1 == 5'd0) ? 32'd0 : regs_q[read_address_1];
    if (write_hit && (write_register_writeback == read_address_1)) begin
      read_data_1 = result_writeback;
    end
  end

  // Read port 2: same behaviour as port 1, evaluated independently.
  always_comb begin
    read_data_2 = (read_address_2 == 5'd0) ? 32'd0 : regs_q[read_address_2];
    if (write_hit && (write_register_writeback == read_address_2)) begin
      read_data_2 = result_writeback;
    end
  end

  // Stored $v0 contents, without bypass.
  assign register_v0 = regs_q[V0_INDEX];

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: reset values, load extraction,
// bypass, zero register, write-enable gating and asynchronous reset.
module tb_writeback_register_file;

  localparam logic [31:0] SP_RST = 32'h0000_1000;
  localparam logic [31:0] GP_RST = 32'h0000_8000;

  logic        clk;
  logic        reset;
  logic        register_write_writeback;
  logic        memory_to_register_writeback;
  logic [31:0] ALU_out_writeback;
  logic [31:0] read_data_writeback;
  logic [2:0]  load_type_writeback;
  logic [4:0]  write_register_writeback;
  logic [4:0]  read_address_1;
  logic [4:0]  read_address_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] result_writeback;
  logic [31:0] register_v0;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_register_file #(
    .SP_RESET_VALUE(SP_RST),
    .GP_RESET_VALUE(GP_RST)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .register_write_writeback     (register_write_writeback),
    .memory_to_register_writeback (memory_to_register_writeback),
    .ALU_out_writeback            (ALU_out_writeback),
    .read_data_writeback          (read_data_writeback),
    .load_type_writeback          (load_type_writeback),
    .write_register_writeback     (write_register_writeback),
    .read_address_1               (read_address_1),
    .read_address_2               (read_address_2),
    .read_data_1                  (read_data_1),
    .read_data_2                  (read_data_2),
    .result_writeback             (result_writeback),
    .register_v0                  (register_v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t load_vecs [12];

  initial begin
    // read_data_writeback = 32'h8012_34F0 for every entry
    load_vecs[0]  = '{3'b001, 2'd0, 32'hFFFF_FF80};  // LB  byte 0 = 80
    load_vecs[1]  = '{3'b001, 2'd1, 32'h0000_0012};  // LB  byte 1 = 12
    load_vecs[2]  = '{3'b001, 2'd3, 32'hFFFF_FFF0};  // LB  byte 3 = F0
    load_vecs[3]  = '{3'b010, 2'd3, 32'h0000_00F0};  // LBU byte 3
    load_vecs[4]  = '{3'b010, 2'd0, 32'h0000_0080};  // LBU byte 0
    load_vecs[5]  = '{3'b011, 2'd2, 32'h0000_34F0};  // LH  lower half
    load_vecs[6]  = '{3'b011, 2'd0, 32'hFFFF_8012};  // LH  upper half
    load_vecs[7]  = '{3'b011, 2'd3, 32'h0000_34F0};  // LH  offset[0] ignored
    load_vecs[8]  = '{3'b100, 2'd0, 32'h0000_8012};  // LHU upper half
    load_vecs[9]  = '{3'b100, 2'd1, 32'h0000_8012};  // LHU offset[0] ignored
    load_vecs[10] = '{3'b000, 2'd2, 32'h8012_34F0};  // LW  offset ignored
    load_vecs[11] = '{3'b111, 2'd1, 32'h8012_34F0};  // unused -> LW
  end

  initial begin
    reset                        = 1'b0;
    register_write_writeback     = 1'b0;
    memory_to_register_writeback = 1'b0;
    ALU_out_writeback            = '0;
    read_data_writeback          = '0;
    load_type_writeback          = 3'b000;
    write_register_writeback     = '0;
    read_address_1               = '0;
    read_address_2               = '0;

    // Asynchronous reset before the first clock edge (first posedge at t=5).
    #2;
    reset          = 1'b1;
    read_address_1 = 5'd29;
    read_address_2 = 5'd5;
    #1;
    check("rst_sp", read_data_1, SP_RST);
    check("rst_r5", read_data_2, 32'd0);
    check("rst_v0", register_v0, 32'd0);
    read_address_1 = 5'd28;
    #1;
    check("rst_gp", read_data_1, GP_RST);

    // Write enable during reset: combinational paths live, storage untouched.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd5;
    ALU_out_writeback        = 32'h1111_1111;
    read_address_1           = 5'd5;
    #1;
    check("rst_result", result_writeback, 32'h1111_1111);
    check("rst_bypass", read_data_1, 32'h1111_1111);
    tick();
    register_write_writeback = 1'b0;
    #1;
    check("rst_wr_ignored", read_data_1, 32'd0);
    reset = 1'b0;
    #1;

    // First edge after reset: ALU write to $v0 with bypass.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd2;
    ALU_out_writeback        = 32'hDEAD_BEEF;
    read_address_1           = 5'd2;
    #1;
    check("v0_bypass", read_data_1, 32'hDEAD_BEEF);
    check("v0_pre_edge", register_v0, 32'd0);
    tick();
    register_write_writeback = 1'b0;
    #1;
    check("v0_stored", register_v0, 32'hDEAD_BEEF);
    check("v0_read", read_data_1, 32'hDEAD_BEEF);

    // Load extraction table.
    memory_to_register_writeback = 1'b1;
    read_data_writeback          = 32'h8012_34F0;
    for (int i = 0; i < 12; i++) begin
      load_type_writeback = load_vecs[i].lt;
      ALU_out_writeback   = {30'h0400_0000, load_vecs[i].off};
      #1;
      check($sformatf("load_%0d", i), result_writeback, load_vecs[i].exp);
    end

    // Store an LB result into reg 9.
    load_type_writeback      = 3'b001;
    ALU_out_writeback        = 32'h1000_0000;
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd9;
    tick();
    register_write_writeback     = 1'b0;
    memory_to_register_writeback = 1'b0;
    read_address_2               = 5'd9;
    #1;
    check("lb_stored_r9", read_data_2, 32'hFFFF_FF80);

    // Register 0 ignores writes.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd0;
    ALU_out_writeback        = 32'h1234_5678;
    read_address_1           = 5'd0;
    #1;
    check("r0_same_cycle", read_data_1, 32'd0);
    check("r0_result", result_writeback, 32'h1234_5678);
    tick();
    register_write_writeback = 1'b0;
    #1;
    check("r0_after", read_data_1, 32'd0);

    // Dual-port bypass, identical and independent addresses.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd9;
    ALU_out_writeback        = 32'hCAFE_0001;
    read_address_1           = 5'd9;
    read_address_2           = 5'd9;
    #1;
    check("dual_p1", read_data_1, 32'hCAFE_0001);
    check("dual_p2", read_data_2, 32'hCAFE_0001);
    read_address_2 = 5'd2;
    #1;
    check("indep_p1", read_data_1, 32'hCAFE_0001);
    check("indep_p2", read_data_2, 32'hDEAD_BEEF);
    register_write_writeback = 1'b0;
    #1;
    check("r9_no_write", read_data_1, 32'hFFFF_FF80);

    // Write-enable gating: reg 3 must hold for 10 cycles, no bypass.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd3;
    ALU_out_writeback        = 32'h0000_0333;
    tick();
    register_write_writeback = 1'b0;
    read_address_2           = 5'd3;
    for (int i = 0; i < 10; i++) begin
      ALU_out_writeback = 32'h7000_0000 + i;
      #1;
      check($sformatf("we0_r3_c%0d", i), read_data_2, 32'h0000_0333);
      tick();
    end
    check("we0_r3_end", read_data_2, 32'h0000_0333);

    // Asynchronous reset between edges discards contents.
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd7;
    ALU_out_writeback        = 32'hA5A5_A5A5;
    tick();
    register_write_writeback = 1'b0;
    read_address_1           = 5'd7;
    #1;
    check("r7_stored", read_data_1, 32'hA5A5_A5A5);
    #2;
    reset = 1'b1;
    #1;
    check("async_r7", read_data_1, 32'd0);
    check("async_v0", register_v0, 32'd0);
    read_address_2 = 5'd29;
    #1;
    check("async_sp", read_data_2, SP_RST);

    // Normal operation resumes after release.
    tick();
    reset = 1'b0;
    register_write_writeback = 1'b1;
    write_register_writeback = 5'd7;
    ALU_out_writeback        = 32'h0BAD_F00D;
    tick();
    register_write_writeback = 1'b0;
    #1;
    check("post_rst_r7", read_data_1, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
